// File: rtl/pmod_dac_sequencer.sv
// rtl/pmod_dac_sequencer.sv - FIFO-buffered sample-rate sequencer feeding the PMOD DAC SPI block
module pmod_dac_sequencer #(
    parameter int RESOLUTION   = 16,
    parameter int DEPTH        = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int MIN_PERIOD   = 64,
    parameter int START_HOLD   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RESOLUTION-1:0]      wr_data,
    input  logic                       wr_en,
    input  logic                       enable,
    input  logic [PERIOD_WIDTH-1:0]    period,
    input  logic                       clear_flags,
    output logic [RESOLUTION-1:0]      dac_din,
    output logic                       dac_load_din,
    output logic                       dac_start,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       busy,
    output logic                       underflow,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] HOLD  = PERIOD_WIDTH'(START_HOLD);
    localparam logic [PERIOD_WIDTH-1:0] ONE   = PERIOD_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

    state_t                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [PERIOD_WIDTH-1:0] eff_q, eff_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [RESOLUTION-1:0]   din_q, din_d;
    logic                    uf_q, uf_d;
    logic                    of_q, of_d;
    logic [RESOLUTION-1:0]   mem [DEPTH];

    logic full_w, empty_w, pop, wr_ok, uf_set, of_set;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        eff_d    = eff_q;
        pop      = 1'b0;
        uf_set   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && !empty_w) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = cnt_q + ONE;
                state_d = START;
            end
            START: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == HOLD) state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + ONE;
                if (cnt_q == eff_q - ONE) begin
                    if (enable && !empty_w) begin
                        pop     = 1'b1;
                        state_d = LOAD;
                    end else begin
                        uf_set  = enable;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Counter reads 0 during LOAD so WAIT expiry lands exactly eff cycles later.
        if (pop) begin
            cnt_d = '0;
            eff_d = (period < MIN_P) ? MIN_P : period;
        end
    end

    always_comb begin
        wr_ok    = wr_en && (!full_w || pop);
        of_set   = wr_en && full_w && !pop;
        wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        din_d    = pop ? mem[rd_ptr_q] : din_q;
        count_d  = count_q;
        if (wr_ok && !pop) count_d = count_q + CW'(1);
        if (!wr_ok && pop) count_d = count_q - CW'(1);
        // A set event in the same cycle as clear_flags keeps the flag high.
        uf_d = uf_set || (uf_q && !clear_flags);
        of_d = of_set || (of_q && !clear_flags);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            eff_q    <= MIN_P;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            din_q    <= '0;
            uf_q     <= 1'b0;
            of_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            eff_q    <= eff_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            din_q    <= din_d;
            uf_q     <= uf_d;
            of_q     <= of_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= wr_data;
    end

    assign dac_din      = din_q;
    assign dac_load_din = (state_q == LOAD);
    assign dac_start    = (state_q == START);
    assign busy         = (state_q != IDLE);
    assign count        = count_q;
    assign full         = full_w;
    assign empty        = empty_w;
    assign underflow    = uf_q;
    assign overflow     = of_q;

endmodule

// File: doc/pmod_dac_sequencer.md
# pmod_dac_sequencer

Sample-rate sequencer that sits directly upstream of the PMOD DAC SPI block. It buffers SoC-written samples in a small FIFO and, at a programmable sample interval, drives the DAC block's `din` / `load_din` / `start` inputs. It guarantees that consecutive transactions are spaced far enough apart for the DAC block's slow-clock SPI transfer and LDAC pulse to complete. Underflow and overflow are reported as sticky flags.

## Interface
- `RESOLUTION`, 16, sample width; matches the DAC block.
- `DEPTH`, 16, FIFO depth in words; power of two, ≥2.
- `PERIOD_WIDTH`, 16, width of `period`.
- `MIN_PERIOD`, 64, minimum clk cycles between consecutive loads; must exceed one full DAC transaction (≥20 slow_clk periods in clk cycles).
- `START_HOLD`, 8, clk cycles `dac_start` is held; must be ≥1 slow_clk period and < `MIN_PERIOD`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_data`  in  RESOLUTION  sample to enqueue.
- `wr_en`  in  1  enqueue strobe, one word per cycle.
- `enable`  in  1  run sequencing.
- `period`  in  PERIOD_WIDTH  requested interval between loads, in clk cycles.
- `clear_flags`  in  1  clears `underflow` and `overflow`.
- `dac_din`  out  RESOLUTION  sample to the DAC block `din`.
- `dac_load_din`  out  1  one-cycle load strobe to the DAC block.
- `dac_start`  out  1  start request to the DAC block.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `busy`  out  1  state ≠ IDLE.
- `underflow`  out  1  sticky; a sample interval expired with the FIFO empty while enabled.
- `overflow`  out  1  sticky; a write was dropped.

## Operation
- Reset values: `dac_din`=0, `dac_load_din`=0, `dac_start`=0, `count`=0, `full`=0, `empty`=1, `busy`=0, `underflow`=0, `overflow`=0. State is IDLE. FIFO pointers and the interval counter are 0.
- **FIFO:**
  - Circular buffer; pointers wrap at DEPTH.
  - A write is accepted if `!full`, or if a pop occurs in the same cycle; in that case `count` is unchanged.
  - A write while full with no pop is dropped and sets `overflow`.
  - A pop happens only on entry to LOAD.
- **Effective interval:** `eff = max(period, MIN_PERIOD)`. `period` is sampled on entry to LOAD; `period`=0 gives `MIN_PERIOD`.
- **State machine:**
  - **IDLE:** if `enable && !empty`, go to LOAD.
  - **LOAD (1 cycle):**
    - `dac_din` is registered from the FIFO head and held until the next LOAD.
    - `dac_load_din`=1; the interval counter is cleared to 0.
    - Go to START.
  - **START (`START_HOLD` cycles):** `dac_start`=1; the counter increments each cycle. Then go to WAIT.
  - **WAIT:** the counter increments each cycle. When counter == `eff`-1, at the next edge:
    - if `enable && !empty`, go to LOAD;
    - if `enable && empty`, set `underflow` and go to IDLE;
    - if `!enable`, go to IDLE.
- **Enable deasserted mid-operation:** never truncates START or WAIT. The interval always completes, so the DAC block is never restarted early.
- **Sticky flags:** `clear_flags` clears both flags. If a set event and `clear_flags` occur in the same cycle, set wins.
- **Reset mid-operation:** all outputs return to reset values immediately and asynchronously, and FIFO contents are discarded.

## Timing
- All outputs are registered or decoded from state; there is no combinational path from inputs to `dac_*`.
- From IDLE, if `enable`=1 and `!empty` are sampled at edge T:
  - `dac_load_din` is high during cycle T+1;
  - `dac_start` is high during cycles T+2 … T+1+`START_HOLD`.
- With sustained enable and a non-empty FIFO, `dac_load_din` pulses are exactly `eff` cycles apart.
- A word written at edge N updates `count`/`empty` after edge N and can be popped on an IDLE→LOAD transition at edge N+1.
- `count` decrements in the LOAD cycle, and `count`/`full` reflect a simultaneous write and pop in the same cycle.

## Test plan
- Reset, write 3 words (0x1111, 0x2222, 0x3333), `period`=100, enable:
  - three `dac_load_din` pulses exactly 100 cycles apart;
  - `dac_din` values 0x1111, 0x2222, 0x3333 in order;
  - `dac_start` is 8 cycles wide, starting one cycle after each load;
  - then `underflow`=1 and `busy`=0.
- `period`=10 (<`MIN_PERIOD`), 2 words: loads are 64 cycles apart.
- Write 17 words while disabled, `DEPTH`=16:
  - `full`=1, `count`=16, `overflow`=1;
  - first sample out is word 0; word 16 is never output.
- FIFO full, and `wr_en` coincides with the LOAD pop: the write is accepted, `count` stays 16, `overflow` stays 0.
- Drop `enable` during START: `dac_start` still lasts 8 cycles, WAIT completes `eff` cycles, then IDLE with no further load.
- Assert `rst` during WAIT: all outputs return to reset values at once. After release, `empty`=1, and no `dac_load_din` occurs until a new write and enable.
